uram_read_requester: RTL and testbench

// - Read-side initiator for one port of the pipelined UltraRAM (no-change mode, read latency NBPIPE+2).
// - Accepts read addresses on a valid/ready request channel and drives the RAM port enable, write-enable and address.
// - Tracks in-flight reads with a token pipeline and captures returning words into a response FIFO.
// - Uses credit flow control so no read data is ever dropped while rsp_ready is low.

---
 rtl/uram_read_requester.sv | 114 +++++++++++
 tb/tb_uram_read_requester.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uram_read_requester.sv
// uram_read_requester: read-side initiator for one pipelined UltraRAM port, with token tracking,
// a credit-protected response FIFO, and optional statistics counters enabled by URAM_READ_REQUESTER_STATS_EN.
module uram_read_requester #(
    parameter int AWIDTH     = 12,
    parameter int DWIDTH     = 72,
    parameter int NBPIPE     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AWIDTH-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    input  logic [DWIDTH-1:0] ram_dout
`ifdef URAM_READ_REQUESTER_STATS_EN
    ,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_stalls
`endif
);
    localparam int LAT = NBPIPE + 2;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < NBPIPE + 3) begin : g_depth_check
        $error("uram_read_requester: FIFO_DEPTH must be >= NBPIPE+3");
    end

    logic [LAT-1:0]    tok_q, tok_d;
    logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]     infl_cnt_q, infl_cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic              fire, push, pop;

    // Handshake, credit check and RAM port drive; a pop gives no same-cycle credit
    always_comb begin
        req_ready = !rst && (({1'b0, fifo_cnt_q} + {1'b0, infl_cnt_q}) < (CW + 1)'(FIFO_DEPTH));
        fire      = req_valid && req_ready;
        push      = tok_q[LAT-1];
        rsp_valid = fifo_cnt_q != '0;
        pop       = rsp_valid && rsp_ready;
        rsp_data  = mem_q[rd_ptr_q];
        ram_en    = fire;
        ram_we    = 1'b0;
        ram_addr  = req_addr;
    end

    // Next state for the token pipe, occupancy counters and FIFO pointers
    always_comb begin
        tok_d      = {tok_q[LAT-2:0], fire};
        infl_cnt_d = (fire && !push) ? infl_cnt_q + 1'b1 :
                     (!fire && push) ? infl_cnt_q - 1'b1 : infl_cnt_q;
        fifo_cnt_d = (push && !pop) ? fifo_cnt_q + 1'b1 :
                     (!push && pop) ? fifo_cnt_q - 1'b1 : fifo_cnt_q;
        wr_ptr_d   = !push ? wr_ptr_q : (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d   = !pop ? rd_ptr_q : (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    // Control state; reset drops all in-flight tokens so late RAM data is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_q      <= '0;
            infl_cnt_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            tok_q      <= tok_d;
            infl_cnt_q <= infl_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage captures returning RAM words; contents need no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ram_dout;
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_cnt_q == CW'(FIFO_DEPTH)));

`ifdef URAM_READ_REQUESTER_STATS_EN
    logic [31:0] stat_reads_q, stat_reads_d, stat_stalls_q, stat_stalls_d;

    // Saturating counters of accepted requests and stalled request cycles
    always_comb begin
        stat_reads_d  = (fire && stat_reads_q != '1) ? stat_reads_q + 1'b1 : stat_reads_q;
        stat_stalls_d = (req_valid && !req_ready && stat_stalls_q != '1) ? stat_stalls_q + 1'b1 : stat_stalls_q;
        stat_reads    = stat_reads_q;
        stat_stalls   = stat_stalls_q;
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end
`endif
endmodule

// File: tb/tb_uram_read_requester.sv
// tb_uram_read_requester: directed scoreboard bench for uram_read_requester with a latency-5 RAM model.
module tb_uram_read_requester;
    localparam int LAT = 5;

    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0;
    logic        req_ready;
    logic [11:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1;
    logic [71:0] rsp_data;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [71:0] ram_dout;
`ifdef URAM_READ_REQUESTER_STATS_EN
    logic [31:0] stat_reads, stat_stalls;
`endif

    uram_read_requester #(.AWIDTH(12), .DWIDTH(72), .NBPIPE(3), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout)
`ifdef URAM_READ_REQUESTER_STATS_EN
        , .stat_reads(stat_reads), .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: mem[a] = a+100, LAT cycles from enable to dout, junk when not enabled
    logic [71:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= ram_en ? 72'(ram_addr) + 72'd100 : 72'hBAD_BAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_dout = pipe[LAT-1];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pops = 0;
    int pop_cyc[$];
    logic [71:0] sb[$];
    logic [71:0] exp_d;

    always @(posedge clk) cyc++;

    // Scoreboard monitor: credit model, RAM port checks and in-order data compare
    always @(negedge clk) begin
        if (rst) begin
            total++;
            assert (req_ready === 1'b0 && rsp_valid === 1'b0 && ram_en === 1'b0 && ram_we === 1'b0)
            else begin bad++; $error("FAIL rst_outs: rdy=%b vld=%b en=%b we=%b required 0 0 0 0", req_ready, rsp_valid, ram_en, ram_we); end
            sb.delete();
        end else begin
            total++;
            assert (req_ready === (sb.size() < 8))
            else begin bad++; $error("FAIL credit: req_ready=%b required %b (outstanding %0d)", req_ready, sb.size() < 8, sb.size()); end
            total++;
            assert (ram_en === (req_valid && sb.size() < 8) && ram_we === 1'b0 && ram_addr === req_addr)
            else begin bad++; $error("FAIL ram_port: en=%b we=%b addr=%0d required en=%b we=0 addr=%0d", ram_en, ram_we, ram_addr, req_valid && sb.size() < 8, req_addr); end
            total++;
            assert (dut.fifo_cnt_q <= 4'd8)
            else begin bad++; $error("FAIL fifo_cnt: %0d required <=8", dut.fifo_cnt_q); end
            if (rsp_valid && rsp_ready) begin
                total++;
                assert (sb.size() != 0)
                else begin bad++; $error("FAIL spurious_rsp: data=%0d required no response", rsp_data); end
                if (sb.size() != 0) begin
                    exp_d = sb.pop_front();
                    total++;
                    assert (rsp_data === exp_d)
                    else begin bad++; $error("FAIL rsp_data: got %0d required %0d", rsp_data, exp_d); end
                end
                pops++;
                pop_cyc.push_back(cyc);
            end
            if (req_valid && req_ready) sb.push_back(72'(req_addr) + 72'd100);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            step();
            n++;
        end
        repeat (2) step();
        total++;
        assert (sb.size() == 0)
        else begin bad++; $error("FAIL drain_timeout: outstanding=%0d required 0", sb.size()); end
    endtask

    initial begin
        int n0;
        int acc;
        // Reset with a request pending: nothing may be accepted
        req_valid = 1;
        repeat (3) step();
        req_valid = 0;
        rst = 0;
        @(negedge clk);
        total++;
        assert (req_ready === 1'b1 && rsp_valid === 1'b0)
        else begin bad++; $error("FAIL post_rst: rdy=%b vld=%b required 1 0", req_ready, rsp_valid); end
        step();

        // Single read of addr 7: enable in cycle 0, rsp_valid first in cycle 6
        req_valid = 1;
        req_addr  = 12'd7;
        @(negedge clk);
        total++;
        assert (ram_en === 1'b1)
        else begin bad++; $error("FAIL single_en: ram_en=%b required 1", ram_en); end
        step();
        req_valid = 0;
        n0 = pops;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            total++;
            assert (rsp_valid === (k == 6))
            else begin bad++; $error("FAIL single_lat: cycle %0d rsp_valid=%b required %b", k, rsp_valid, k == 6); end
            step();
        end
        total++;
        assert (pops - n0 == 1)
        else begin bad++; $error("FAIL single_cnt: %0d responses required 1", pops - n0); end

        // Streaming 0..31 back-to-back with rsp_ready high
        n0 = pops;
        for (int i = 0; i < 32; i++) begin
            req_valid = 1;
            req_addr  = 12'(i);
            @(negedge clk);
            total++;
            assert (req_ready === 1'b1)
            else begin bad++; $error("FAIL stream_ready: addr %0d req_ready=%b required 1", i, req_ready); end
            step();
        end
        req_valid = 0;
        drain(40);
        total++;
        assert (pops - n0 == 32 && pop_cyc[n0 + 31] - pop_cyc[n0] == 31)
        else begin bad++; $error("FAIL stream_rate: %0d responses required 32 on consecutive cycles", pops - n0); end

        // Alternating rsp_ready with 20 reads
        n0 = pops;
        acc = 0;
        for (int c = 0; c < 200 && acc < 20; c++) begin
            req_valid = 1;
            req_addr  = 12'(200 + acc);
            rsp_ready = c[0];
            @(negedge clk);
            if (req_ready) acc++;
            step();
        end
        req_valid = 0;
        rsp_ready = 1;
        drain(40);
        total++;
        assert (acc == 20 && pops - n0 == 20)
        else begin bad++; $error("FAIL alt_cnt: accepted %0d responses %0d required 20 20", acc, pops - n0); end

        // Reset mid-flight: three reads lost, then a single read of addr 5
        for (int i = 0; i < 3; i++) begin
            req_valid = 1;
            req_addr  = 12'(50 + i);
            step();
        end
        req_valid = 0;
        rst = 1;
        step();
        rst = 0;
        n0 = pops;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            assert (rsp_valid === 1'b0)
            else begin bad++; $error("FAIL lost_reads: rsp_valid=%b data=%0d required 0", rsp_valid, rsp_data); end
            step();
        end
        req_valid = 1;
        req_addr  = 12'd5;
        step();
        req_valid = 0;
        drain(20);
        total++;
        assert (pops - n0 == 1)
        else begin bad++; $error("FAIL post_rst_read: %0d responses required 1", pops - n0); end

        // Backpressure from a fresh reset: 8 accepted, then stalls
        rst = 1;
        step();
        rst = 0;
        rsp_ready = 0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            req_valid = 1;
            req_addr  = 12'(40 + acc);
            @(negedge clk);
            if (req_ready) acc++;
            step();
        end
        req_valid = 0;
        @(negedge clk);
        total++;
        assert (acc == 8 && req_ready === 1'b0)
        else begin bad++; $error("FAIL bp_accept: accepted %0d ready=%b required 8 0", acc, req_ready); end
`ifdef URAM_READ_REQUESTER_STATS_EN
        total++;
        assert (stat_reads === 32'd8 && stat_stalls === 32'd4)
        else begin bad++; $error("FAIL stats: reads=%0d stalls=%0d required 8 4", stat_reads, stat_stalls); end
`endif
        step();
        rsp_ready = 1;
        n0 = pops;
        @(negedge clk);
        total++;
        assert (rsp_valid === 1'b1 && req_ready === 1'b0)
        else begin bad++; $error("FAIL bp_first_pop: vld=%b rdy=%b required 1 0", rsp_valid, req_ready); end
        step();
        @(negedge clk);
        total++;
        assert (req_ready === 1'b1)
        else begin bad++; $error("FAIL bp_credit_return: req_ready=%b required 1", req_ready); end
        drain(20);
        total++;
        assert (pops - n0 == 8)
        else begin bad++; $error("FAIL bp_drain: %0d responses required 8", pops - n0); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
